// File: rtl/winograd_mul_arbiter.sv
// Round-robin arbiter with burst lock in front of one shared pipelined signed multiplier.
// Products return in accept order after LAT cycles, tagged with the issuing requester id.
module winograd_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int LAT  = 2,
    parameter int IDW  = (($clog2(NREQ) > 1) ? $clog2(NREQ) : 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_last,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [2*W-1:0]      resp_p,
    output logic                busy
);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state_r;
    logic [IDW-1:0]        ptr_r;
    logic [IDW-1:0]        owner_r;

    logic                  found_s;
    logic [IDW-1:0]        win_s;
    logic [IDW-1:0]        sel_s;
    logic [NREQ-1:0]       ready_s;
    logic                  accept_s;
    logic                  last_s;
    logic [W-1:0]          a_sel_s;
    logic [W-1:0]          b_sel_s;
    logic signed [2*W-1:0] a_ext_s;
    logic signed [2*W-1:0] b_ext_s;
    logic signed [2*W-1:0] prod_s;

    logic [LAT-1:0]        pv_r;
    logic [2*W-1:0]        pp_r  [LAT];
    logic [IDW-1:0]        pid_r [LAT];
    logic [LAT-1:0]        sv_s;
    logic [2*W-1:0]        sp_s  [LAT];
    logic [IDW-1:0]        sid_s [LAT];

    function automatic int wrap(input int p, input int k);
        return (p + k) % NREQ;
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] x);
        logic [IDW-1:0] n;
        if (x == IDW'(NREQ - 1)) begin
            n = '0;
        end else begin
            n = x + IDW'(1);
        end
        return n;
    endfunction

    // Round-robin search for the first valid requester starting at ptr.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req_valid[wrap(int'(ptr_r), k)]) begin
                found_s = 1'b1;
                win_s   = IDW'(wrap(int'(ptr_r), k));
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant generation; a locked owner excludes everyone else even when idle.
    always_comb begin
        ready_s = '0;
        if (rst) begin
            ready_s = '0;
        end else if (state_r == ST_LOCKED) begin
            ready_s[owner_r] = req_valid[owner_r];
        end else if (found_s) begin
            ready_s[win_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Selected operands and the full-width signed product.
    always_comb begin
        if (state_r == ST_LOCKED) begin
            sel_s = owner_r;
        end else begin
            sel_s = win_s;
        end
        accept_s = |(ready_s & req_valid);
        last_s   = req_last[sel_s];
        a_sel_s  = req_a[int'(sel_s)*W +: W];
        b_sel_s  = req_b[int'(sel_s)*W +: W];
        a_ext_s  = {{W{a_sel_s[W-1]}}, a_sel_s};
        b_ext_s  = {{W{b_sel_s[W-1]}}, b_sel_s};
        prod_s   = a_ext_s * b_ext_s;
    end

    // Arbiter state: ptr only advances when a single beat or a burst ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_ARB;
            ptr_r   <= '0;
            owner_r <= '0;
        end else if (accept_s) begin
            case (state_r)
                ST_ARB: begin
                    if (last_s) begin
                        ptr_r <= next_id(win_s);
                    end else begin
                        state_r <= ST_LOCKED;
                        owner_r <= win_s;
                    end
                end
                ST_LOCKED: begin
                    if (last_s) begin
                        state_r <= ST_ARB;
                        ptr_r   <= next_id(owner_r);
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

    // Stage inputs: stage 0 takes the accepted beat, later stages the previous stage.
    always_comb begin
        sv_s[0]  = accept_s;
        sp_s[0]  = prod_s;
        sid_s[0] = sel_s;
        for (int g = 1; g < LAT; g++) begin
            sv_s[g]  = pv_r[g-1];
            sp_s[g]  = pp_r[g-1];
            sid_s[g] = pid_r[g-1];
        end
    end

    // Product pipeline; data registers only load with a valid beat so the output holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_r <= '0;
            for (int g = 0; g < LAT; g++) begin
                pp_r[g]  <= '0;
                pid_r[g] <= '0;
            end
        end else begin
            pv_r <= sv_s;
            for (int g = 0; g < LAT; g++) begin
                if (sv_s[g]) begin
                    pp_r[g]  <= sp_s[g];
                    pid_r[g] <= sid_s[g];
                end
            end
        end
    end

    assign req_ready  = ready_s;
    assign resp_valid = pv_r[LAT-1];
    assign resp_p     = pp_r[LAT-1];
    assign resp_id    = pid_r[LAT-1];
    assign busy       = (state_r == ST_LOCKED) | (|pv_r);

endmodule

// File: tb/tb_winograd_mul_arbiter.sv
// Scoreboard bench: three builds (LAT=1,2,3) share stimulus; a spec-level model predicts grants and products.
module tb_winograd_mul_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;
    localparam int NL   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rdy [NL];
    logic              rv  [NL];
    logic [IDW-1:0]    rid [NL];
    logic [2*W-1:0]    rp  [NL];
    logic              bsy [NL];

    for (genvar g = 0; g < NL; g++) begin : g_dut
        winograd_mul_arbiter #(.NREQ(NREQ), .W(W), .LAT(g + 1), .IDW(IDW)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
            .req_ready(rdy[g]), .resp_valid(rv[g]), .resp_id(rid[g]), .resp_p(rp[g]),
            .busy(bsy[g])
        );
    end

    // scoreboard: every accept, in order, with its accept cycle
    int     q_id  [$];
    longint q_p   [$];
    int     q_cyc [$];
    int     rd [NL];
    int     base = 0;

    // reference arbiter state
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int cyc      = 0;
    bit acc_any  = 1'b0;
    int acc_i    = 0;
    bit acc_last = 1'b0;
    int n_acc    = 0;

    int n_cmp = 0;
    int n_bad = 0;
    bit final_chk = 1'b0;
    int tmo = 0;

    // model state advances with the clock; rst clears it immediately
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked <= 1'b0;
            m_ptr    <= 0;
            m_owner  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (acc_any) begin
                if (m_locked) begin
                    if (acc_last) begin
                        m_locked <= 1'b0;
                        m_ptr    <= (m_owner + 1) % NREQ;
                    end
                end else if (acc_last) begin
                    m_ptr <= (acc_i + 1) % NREQ;
                end else begin
                    m_locked <= 1'b1;
                    m_owner  <= acc_i;
                end
            end
        end
    end

    // grant prediction, scoreboard push and response monitor, all away from the active edge
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        bit found, eb, due;
        int L;
        longint pa, pb;
        er = '0;
        found = 1'b0;
        if (!rst) begin
            if (m_locked) begin
                if (req_valid[m_owner]) er[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid[(m_ptr + k) % NREQ]) begin
                        found = 1'b1;
                        er[(m_ptr + k) % NREQ] = 1'b1;
                    end
                end
            end
        end
        for (int g = 0; g < NL; g++) begin
            n_cmp++;
            if (rdy[g] !== er) begin
                n_bad++;
                $display("FAIL ready lat%0d cyc%0d: got %b want %b", g + 1, cyc, rdy[g], er);
            end
        end
        acc_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (er[i] && req_valid[i]) begin
                acc_any  = 1'b1;
                acc_i    = i;
                acc_last = req_last[i];
            end
        end
        if (acc_any) begin
            pa = $signed(req_a[acc_i*W +: W]);
            pb = $signed(req_b[acc_i*W +: W]);
            q_id.push_back(acc_i);
            q_p.push_back(pa * pb);
            q_cyc.push_back(cyc);
            n_acc++;
        end
        for (int g = 0; g < NL; g++) begin
            L = g + 1;
            if (rd[g] < base) rd[g] = base;
            if (rst) begin
                n_cmp++;
                if (rv[g] !== 1'b0 || bsy[g] !== 1'b0 || rid[g] !== '0 || rp[g] !== '0) begin
                    n_bad++;
                    $display("FAIL reset lat%0d: got v=%b busy=%b id=%0d p=%0d want all 0",
                             L, rv[g], bsy[g], rid[g], rp[g]);
                end
            end else begin
                eb = m_locked;
                for (int e = rd[g]; e < q_id.size(); e++) begin
                    if (q_cyc[e] + 1 <= cyc && cyc <= q_cyc[e] + L) eb = 1'b1;
                end
                n_cmp++;
                if (bsy[g] !== eb) begin
                    n_bad++;
                    $display("FAIL busy lat%0d cyc%0d: got %b want %b", L, cyc, bsy[g], eb);
                end
                due = (rd[g] < q_id.size()) && (q_cyc[rd[g]] + L == cyc);
                if (rv[g] === 1'b1) begin
                    n_cmp++;
                    if (!due) begin
                        n_bad++;
                        $display("FAIL unexpected resp lat%0d cyc%0d: got id=%0d p=%0d want none",
                                 L, cyc, rid[g], $signed(rp[g]));
                    end else begin
                        if (rid[g] != IDW'(q_id[rd[g]]) || longint'($signed(rp[g])) != q_p[rd[g]]) begin
                            n_bad++;
                            $display("FAIL resp lat%0d cyc%0d: got id=%0d p=%0d want id=%0d p=%0d",
                                     L, cyc, rid[g], $signed(rp[g]), q_id[rd[g]], q_p[rd[g]]);
                        end
                        rd[g]++;
                    end
                end else if (due) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing resp lat%0d cyc%0d: got none want id=%0d p=%0d",
                             L, cyc, q_id[rd[g]], q_p[rd[g]]);
                    rd[g]++;
                end
            end
            if (final_chk) begin
                n_cmp++;
                if (rd[g] != q_id.size()) begin
                    n_bad++;
                    $display("FAIL drain lat%0d: got %0d responses want %0d", L, rd[g], q_id.size());
                end
            end
        end
        if (final_chk) begin
            n_cmp++;
            if (tmo != 0) begin
                n_bad++;
                $display("FAIL timeout: got %0d stalled waits want 0", tmo);
            end
        end
    end

    function automatic logic [W-1:0] opnd(input int mode);
        logic [W-1:0] v;
        v = W'($urandom);
        if (mode != 0) begin
            case ($urandom_range(0, 5))
                0: v = 16'h8000;
                1: v = 16'h7fff;
                2: v = 16'h0000;
                3: v = 16'hffff;
                4: v = 16'h0001;
                default: v = W'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic put(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
        req_valid[i] = 1'b1;
        req_last[i]  = l;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // advance one cycle; the requester the model saw accepted drops its beat
    task automatic step();
        @(posedge clk);
        #1;
        if (acc_any) req_valid[acc_i] = 1'b0;
    endtask

    task automatic wait_clear(input logic [NREQ-1:0] m);
        for (int t = 0; t < 30 && (req_valid & m) != '0; t++) step();
        if ((req_valid & m) != '0) tmo++;
    endtask

    task automatic fill(input int mode, input int pv, input int pl);
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < pv)
                put(i, opnd(mode), opnd(mode), $urandom_range(0, 99) < pl);
        end
    endtask

    task automatic rst_pulse();
        #1;
        rst  = 1'b1;
        base = q_id.size();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int start;
        req_valid = '0;
        req_last  = '0;
        req_a     = '0;
        req_b     = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // single beat from requester 2, then 1 and 3 together: 3 must win (ptr=3)
        step();
        put(2, 16'sd7, -16'sd3, 1'b1);
        wait_clear(4'b0100);
        repeat (4) step();
        put(1, opnd(0), opnd(0), 1'b1);
        put(3, opnd(0), opnd(0), 1'b1);
        wait_clear(4'b1010);
        repeat (4) step();

        // round-robin with everyone continuously valid
        rst_pulse();
        for (int c = 0; c < 24; c++) begin
            step();
            fill(0, 100, 100);
        end
        req_valid = '0;
        repeat (4) step();

        // burst of 4 from requester 1 with an owner-idle gap, 0 and 3 waiting
        put(1, opnd(0), opnd(0), 1'b0);
        wait_clear(4'b0010);
        put(0, opnd(0), opnd(0), 1'b1);
        put(3, opnd(0), opnd(0), 1'b1);
        for (int b = 2; b <= 4; b++) begin
            if (b == 3) step();
            put(1, opnd(0), opnd(0), b == 4);
            wait_clear(4'b0010);
        end
        wait_clear(4'b1001);
        repeat (4) step();

        // extremes
        put(0, 16'h8000, 16'h8000, 1'b1); wait_clear(4'b0001);
        put(0, 16'h8000, 16'h7fff, 1'b1); wait_clear(4'b0001);
        put(2, 16'h0000, 16'h3039, 1'b1); wait_clear(4'b0100);
        for (int c = 0; c < 40; c++) begin
            step();
            fill(1, 60, 50);
        end

        // reset mid-burst with products in flight
        rst_pulse();
        req_valid = '0;
        step();
        put(0, opnd(1), opnd(1), 1'b0);
        wait_clear(4'b0001);
        for (int i = 1; i < NREQ; i++) put(i, opnd(0), opnd(0), 1'b1);
        put(0, opnd(1), opnd(1), 1'b0);
        wait_clear(4'b0001);
        put(0, opnd(1), opnd(1), 1'b0);
        wait_clear(4'b0001);
        put(0, opnd(0), opnd(0), 1'b1);
        rst_pulse();
        for (int c = 0; c < 10; c++) begin
            step();
            fill(0, 100, 100);
        end

        // random traffic: at least 50 accepts
        start = n_acc;
        for (int c = 0; c < 600 && n_acc < start + 50; c++) begin
            step();
            fill(0, 70, 40);
        end
        if (n_acc < start + 50) tmo++;
        for (int c = 0; c < 100 && req_valid != '0; c++) begin
            if (m_locked && !req_valid[m_owner]) put(m_owner, opnd(0), opnd(0), 1'b1);
            step();
        end
        if (req_valid != '0) tmo++;
        repeat (6) step();

        final_chk = 1'b1;
        @(negedge clk);
        #1;
        final_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
